// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cache-bus port between instruction fetch and the memory stage.
// One latched, single-beat transaction at a time; D side wins contention up to a streak limit.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ireq_valid,
    input  logic [63:0] iaddr,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,

    input  logic        dreq_valid,
    input  logic [63:0] daddr,
    input  logic        dis_write,
    input  logic [2:0]  dsize,
    input  logic [7:0]  dstrobe,
    input  logic [63:0] dwdata,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,

    output logic        creq_valid,
    output logic [63:0] creq_addr,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [2:0] MSIZE_32BITS = 3'd2;
    localparam logic [3:0] STREAK_MAX   = 4'(MAX_D_STREAK);

    state_e      state_q, state_d;
    logic [3:0]  d_streak_q, d_streak_d;
    logic [63:0] addr_q, addr_d;
    logic        is_write_q, is_write_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] data_q, data_d;

    logic complete;
    logic busy;

    assign complete = cresp_ready & cresp_last;
    assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            d_streak_q <= '0;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            size_q     <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            size_q     <= size_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        size_d     = size_q;
        strobe_d   = strobe_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                // Fetch is forced only when it is actually waiting and D has used its streak.
                if (dreq_valid && !(ireq_valid && d_streak_q == STREAK_MAX)) begin
                    state_d    = BUSY_D;
                    addr_d     = daddr;
                    is_write_d = dis_write;
                    size_d     = dsize;
                    strobe_d   = dis_write ? dstrobe : '0;
                    data_d     = dis_write ? dwdata : '0;
                    if (ireq_valid)
                        d_streak_d = (d_streak_q == STREAK_MAX) ? STREAK_MAX : d_streak_q + 4'd1;
                    else
                        d_streak_d = '0;
                end else if (ireq_valid) begin
                    state_d    = BUSY_I;
                    addr_d     = iaddr;
                    is_write_d = 1'b0;
                    size_d     = MSIZE_32BITS;
                    strobe_d   = '0;
                    data_d     = '0;
                    d_streak_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (complete)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign creq_valid    = busy;
    assign creq_addr     = busy ? addr_q : '0;
    assign creq_is_write = busy & is_write_q;
    assign creq_size     = busy ? size_q : '0;
    assign creq_strobe   = busy ? strobe_q : '0;
    assign creq_data     = busy ? data_q : '0;

    assign iresp_data_ok = (state_q == BUSY_I) & complete;
    assign dresp_data_ok = (state_q == BUSY_D) & complete;
    assign iresp_data    = !iresp_data_ok ? '0 :
                           (addr_q[2] ? cresp_data[63:32] : cresp_data[31:0]);
    assign dresp_data    = dresp_data_ok ? cresp_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter, built with MAX_D_STREAK = 2.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] iaddr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] daddr;
    logic        dis_write;
    logic [2:0]  dsize;
    logic [7:0]  dstrobe;
    logic [63:0] dwdata;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid;
    logic [63:0] creq_addr;
    logic        creq_is_write;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready;
    logic        cresp_last;
    logic [63:0] cresp_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .iaddr         (iaddr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .daddr         (daddr),
        .dis_write     (dis_write),
        .dsize         (dsize),
        .dstrobe       (dstrobe),
        .dwdata        (dwdata),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .creq_valid    (creq_valid),
        .creq_addr     (creq_addr),
        .creq_is_write (creq_is_write),
        .creq_size     (creq_size),
        .creq_strobe   (creq_strobe),
        .creq_data     (creq_data),
        .cresp_ready   (cresp_ready),
        .cresp_last    (cresp_last),
        .cresp_data    (cresp_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq_valid  = 1'b0;
        iaddr       = '0;
        dreq_valid  = 1'b0;
        daddr       = '0;
        dis_write   = 1'b0;
        dsize       = '0;
        dstrobe     = '0;
        dwdata      = '0;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        checks++;
        if (creq_valid !== 1'b0 || creq_addr !== 64'd0 || creq_size !== 3'd0 ||
            iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: creq_valid=%b addr=%h size=%h iok=%b dok=%b required all 0",
                     creq_valid, creq_addr, creq_size, iresp_data_ok, dresp_data_ok);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        ireq_valid = 1'b1;
        iaddr      = 64'h0000_0000_8000_0004;
        #1;
        checks++;
        if (creq_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_not_yet_valid: creq_valid=%b required 0", creq_valid);
        end
        tick();
        checks++;
        if (creq_valid !== 1'b1 || creq_addr !== 64'h0000_0000_8000_0004 ||
            creq_size !== 3'd2 || creq_is_write !== 1'b0 || creq_strobe !== 8'h00 || creq_data !== 64'd0) begin
            errors++;
            $display("FAIL fetch_creq: valid=%b addr=%h size=%h wr=%b strb=%h data=%h required 1 80000004 2 0 00 0",
                     creq_valid, creq_addr, creq_size, creq_is_write, creq_strobe, creq_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (iresp_data_ok !== 1'b0 || creq_valid !== 1'b1) begin
                errors++;
                $display("FAIL fetch_wait%0d: iok=%b creq_valid=%b required 0 1", i, iresp_data_ok, creq_valid);
            end
        end
        cresp_ready = 1'b1;
        cresp_last  = 1'b1;
        cresp_data  = 64'hAAAA_BBBB_1111_2222;
        #1;
        checks++;
        if (iresp_data_ok !== 1'b1 || iresp_data !== 32'hAAAA_BBBB || dresp_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: iok=%b data=%h dok=%b required 1 aaaabbbb 0",
                     iresp_data_ok, iresp_data, dresp_data_ok);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (iresp_data_ok !== 1'b0 || creq_valid !== 1'b0 || creq_addr !== 64'd0 || iresp_data !== 32'd0) begin
            errors++;
            $display("FAIL fetch_after: iok=%b creq_valid=%b addr=%h idata=%h required 0 0 0 0",
                     iresp_data_ok, creq_valid, creq_addr, iresp_data);
        end
        tick();
    endtask

    task automatic test_store();
        dreq_valid = 1'b1;
        daddr      = 64'h100;
        dis_write  = 1'b1;
        dsize      = 3'd3;
        dstrobe    = 8'hFF;
        dwdata     = 64'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (creq_valid !== 1'b1 || creq_addr !== 64'h100 || creq_is_write !== 1'b1 ||
                creq_size !== 3'd3 || creq_strobe !== 8'hFF || creq_data !== 64'hDEAD_BEEF || dresp_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL store_hold%0d: valid=%b addr=%h wr=%b size=%h strb=%h data=%h dok=%b required 1 100 1 3 ff deadbeef 0",
                         i, creq_valid, creq_addr, creq_is_write, creq_size, creq_strobe, creq_data, dresp_data_ok);
            end
            tick();
        end
        cresp_ready = 1'b1;
        cresp_last  = 1'b1;
        cresp_data  = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++;
        if (dresp_data_ok !== 1'b1 || dresp_data !== 64'h0123_4567_89AB_CDEF || iresp_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: dok=%b data=%h iok=%b required 1 0123456789abcdef 0",
                     dresp_data_ok, dresp_data, iresp_data_ok);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (dresp_data_ok !== 1'b0 || creq_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_after: dok=%b creq_valid=%b required 0 0", dresp_data_ok, creq_valid);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [5:0] exp_d;
        exp_d = 6'b011011;
        ireq_valid = 1'b1;
        iaddr      = 64'h1000;
        dreq_valid = 1'b1;
        daddr      = 64'h2000;
        dis_write  = 1'b0;
        dsize      = 3'd3;
        for (int g = 0; g < 6; g++) begin
            tick();
            checks++;
            if (creq_valid !== 1'b1 || creq_addr !== (exp_d[g] ? 64'h2000 : 64'h1000)) begin
                errors++;
                $display("FAIL contention_grant%0d: valid=%b addr=%h required 1 %h",
                         g, creq_valid, creq_addr, exp_d[g] ? 64'h2000 : 64'h1000);
            end
            cresp_ready = 1'b1;
            cresp_last  = 1'b1;
            cresp_data  = 64'h5555_6666_7777_8888;
            #1;
            checks++;
            if (dresp_data_ok !== exp_d[g] || iresp_data_ok !== !exp_d[g] ||
                (!exp_d[g] && iresp_data !== 32'h7777_8888)) begin
                errors++;
                $display("FAIL contention_resp%0d: dok=%b iok=%b idata=%h required dok=%b iok=%b idata=77778888",
                         g, dresp_data_ok, iresp_data_ok, iresp_data, exp_d[g], !exp_d[g]);
            end
            tick();
            cresp_ready = 1'b0;
            cresp_last  = 1'b0;
            cresp_data  = '0;
            #1;
            checks++;
            if (creq_valid !== 1'b0) begin
                errors++;
                $display("FAIL contention_idle%0d: creq_valid=%b required 0", g, creq_valid);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_requester_change();
        dreq_valid = 1'b1;
        daddr      = 64'h200;
        dis_write  = 1'b1;
        dsize      = 3'd2;
        dstrobe    = 8'h0F;
        dwdata     = 64'h1234;
        tick();
        daddr      = 64'h300;
        dwdata     = 64'h5555;
        dstrobe    = 8'hF0;
        #1;
        checks++;
        if (creq_addr !== 64'h200 || creq_data !== 64'h1234 || creq_strobe !== 8'h0F) begin
            errors++;
            $display("FAIL change_latched: addr=%h data=%h strb=%h required 200 1234 0f",
                     creq_addr, creq_data, creq_strobe);
        end
        dreq_valid = 1'b0;
        tick();
        checks++;
        if (creq_valid !== 1'b1 || creq_addr !== 64'h200) begin
            errors++;
            $display("FAIL change_still_busy: valid=%b addr=%h required 1 200", creq_valid, creq_addr);
        end
        cresp_ready = 1'b1;
        cresp_last  = 1'b1;
        cresp_data  = 64'h9;
        #1;
        checks++;
        if (dresp_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL change_flush_ok: dok=%b required 1", dresp_data_ok);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        ireq_valid = 1'b1;
        iaddr      = 64'h40;
        tick();
        checks++;
        if (creq_valid !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_busy: creq_valid=%b required 1", creq_valid);
        end
        ireq_valid  = 1'b0;
        cresp_ready = 1'b1;
        cresp_last  = 1'b1;
        cresp_data  = 64'hFFFF;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (creq_valid !== 1'b0 || creq_addr !== 64'd0 || creq_size !== 3'd0 ||
            iresp_data_ok !== 1'b0 || iresp_data !== 32'd0 || dresp_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_async: valid=%b addr=%h size=%h iok=%b idata=%h dok=%b required all 0",
                     creq_valid, creq_addr, creq_size, iresp_data_ok, iresp_data, dresp_data_ok);
        end
        #1;
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (creq_valid !== 1'b0 || iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL resetmid_idle%0d: valid=%b iok=%b dok=%b required 0 0 0",
                         i, creq_valid, iresp_data_ok, dresp_data_ok);
            end
        end
    endtask

    task automatic test_spurious();
        cresp_ready = 1'b1;
        cresp_last  = 1'b1;
        cresp_data  = 64'hCAFE;
        #1;
        checks++;
        if (iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0 || dresp_data !== 64'd0) begin
            errors++;
            $display("FAIL spurious_ok: iok=%b dok=%b ddata=%h required 0 0 0",
                     iresp_data_ok, dresp_data_ok, dresp_data);
        end
        tick();
        checks++;
        if (creq_valid !== 1'b0 || iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL spurious_state: valid=%b iok=%b dok=%b required 0 0 0",
                     creq_valid, iresp_data_ok, dresp_data_ok);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store();
        test_contention();
        test_requester_change();
        test_reset_mid();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single cache-bus port between instruction fetch (I side, read-only) and the memory stage (D side, loads/stores). Requests are granted one at a time, latched, and forwarded as single-beat transactions; the response is steered back to the owner. D side wins contention as the older instruction, bounded by a streak limit so fetch cannot starve. Sits between the IF/MEM pipeline stages and the bus/cache interface.

## Interface
- MAX_D_STREAK, default 4: consecutive D grants allowed while I is pending before I is forced; range 1..15.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ireq_valid  in  1  fetch request; held stable with iaddr until iresp_data_ok
- iaddr  in  64  fetch address; transfer is always 32-bit read
- iresp_data_ok  out  1  fetch response valid, one cycle
- iresp_data  out  32  fetched instruction, valid with iresp_data_ok
- dreq_valid  in  1  data request; held stable with all D fields until dresp_data_ok
- daddr  in  64  data address
- dis_write  in  1  1 = store
- dsize  in  3  MemSizeType encoding (8/16/32/64 bits)
- dstrobe  in  8  byte write enables; ignored for loads
- dwdata  in  64  store data
- dresp_data_ok  out  1  data response valid, one cycle
- dresp_data  out  64  load data, valid with dresp_data_ok
- creq_valid  out  1  downstream request valid
- creq_addr  out  64  latched address
- creq_is_write  out  1  latched write flag (0 for I)
- creq_size  out  3  latched size (MSize_32bits for I)
- creq_strobe  out  8  latched strobe (0 for I and loads)
- creq_data  out  64  latched store data (0 for I)
- cresp_ready  in  1  downstream response handshake
- cresp_last  in  1  final beat; completion = cresp_ready & cresp_last
- cresp_data  in  64  downstream read data

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset -> IDLE.
- IDLE: both pending -> BUSY_D, unless d_streak == MAX_D_STREAK -> BUSY_I. Only one pending -> that side. None -> stay.
- On grant edge, all creq_* fields register from the granted requester; they hold constant for the whole transaction.
- creq_valid = 1 exactly in BUSY_I / BUSY_D (decoded from state register).
- BUSY_x: completion -> x data_ok = 1 same cycle, data passes through combinationally, state -> IDLE next edge. No completion -> stay.
- iresp_data = cresp_data[31:0] if creq_addr[2] = 0, else cresp_data[63:32]. dresp_data = cresp_data unmodified (extension done in WB).
- d_streak (4-bit): increments on a D grant while ireq_valid = 1 (saturating at MAX_D_STREAK); clears on any I grant, or on a D grant with ireq_valid = 0.
- A started transaction always completes. If the requester drops valid mid-transaction (flush), data_ok still pulses; the requester discards it.
- Completion seen in IDLE is ignored; no data_ok.
- Outputs are 0 whenever the corresponding data_ok/valid is 0.

## Timing
- Reset values: state IDLE, d_streak 0, all creq_* 0, iresp_data_ok 0, dresp_data_ok 0. Assertion mid-transaction clears immediately (async); the transaction is abandoned without data_ok.
- Request at cycle N (IDLE) -> creq_valid at N+1; earliest data_ok at N+1 if the downstream completes in that cycle.
- After completion, one mandatory IDLE cycle; back-to-back issue spacing is 2 cycles minimum.
- Requests arriving while BUSY wait; arbitration uses only the values present in the IDLE cycle.
- data_ok never asserts for both sides in the same cycle.

## Test plan
- Lone fetch: ireq_valid, iaddr=0x8000_0004; downstream completes 3 cycles after creq_valid with cresp_data=0xAAAA_BBBB_1111_2222 -> creq_size=32-bit, is_write=0; iresp_data_ok one cycle, iresp_data=0xAAAA_BBBB.
- Store: daddr=0x100, dsize=64-bit, dstrobe=0xFF, dwdata=0xDEAD_BEEF -> creq_* match and stay stable over 5 wait cycles; dresp_data_ok one cycle at completion.
- Contention, MAX_D_STREAK=2: both valid every IDLE cycle -> grant order D, D, I, D, D, I; d_streak clears after each I grant.
- Requester change mid-transaction: change daddr/dwdata while BUSY_D -> creq_addr/creq_data unchanged; drop dreq_valid -> dresp_data_ok still pulses at completion.
- Reset mid-transaction: assert reset in BUSY_I, no clock edge -> creq_valid and all outputs 0 immediately; after release with no requests, state stays IDLE, no data_ok.
- Spurious completion: cresp_ready=cresp_last=1 in IDLE -> no data_ok, no state change.
